scope_capture_buffer: RTL and testbench
=======================================

// Module: scope_capture_buffer
// PURPOSE
//  Downstream of the scope trigger controller: records i_adc_data into a circular
//  sample RAM while the controller reports busy, freezes on done, then streams the
//  captured record oldest-first to the host/readout interface. Pre-trigger history
//  is preserved by the circular write; the record ends at the controller's done.
// PARAMETERS
//  DEPTH   512  samples per record; power of two, >= 4
//  DATA_W  8    sample width; matches controller ADC width
//  ADDR_W  9    clog2(DEPTH); taken from shared package
// PORTS
//  clk          in   1       single clock for all logic
//  rst_n        in   1       asynchronous reset, active-low
//  i_adc_data   in   DATA_W  ADC sample, same stream the controller sees
//  i_sample_en  in   1       sample strobe; write only when 1
//  i_busy       in   1       controller busy (capturing)
//  i_done       in   1       controller done (record complete)
//  i_rd_start   in   1       pulse: begin readout of frozen record
//  i_rd_req     in   1       request next sample during readout
//  o_ready      out  1       record frozen, readable
//  o_rd_valid   out  1       o_rd_data valid this cycle (1-cycle pulse)
//  o_rd_data    out  DATA_W  read sample
//  o_rd_last    out  1       with o_rd_valid: final sample of record
//  o_count      out  ADDR_W+1 samples in record (saturates at DEPTH)
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, all outputs 0.
//  FSM states (one-hot, shared package): IDLE, WRITE, READY, READ.
//  IDLE : rising edge of i_busy -> WRITE; clears count, wr_ptr unchanged.
//  WRITE: each cycle with i_sample_en=1 and i_done=0: RAM[wr_ptr]<=i_adc_data,
//         wr_ptr+1 (wraps DEPTH-1->0), count+1 saturating at DEPTH.
//         i_done=1 -> READY; sample of that cycle NOT written.
//  READY: o_ready=1. i_rd_start -> READ; rd_ptr = (count<DEPTH) ? wr_ptr-count : wr_ptr
//         (mod DEPTH, i.e. oldest sample); rd_left=count. count=0 -> stay READY.
//  READ : o_ready=1. i_rd_req with no read outstanding -> RAM read issued;
//         o_rd_valid=1 exactly one cycle later with o_rd_data=RAM[rd_ptr];
//         rd_ptr+1 (wrap), rd_left-1. i_rd_req while outstanding is ignored
//         (max throughput one sample / 2 cycles). o_rd_last=1 on the word
//         where rd_left reaches 0; state -> IDLE the same cycle, o_ready->0.
//  Re-arm: rising i_busy in READY or READ aborts readout -> WRITE, count=0;
//         an outstanding read still returns its o_rd_valid pulse, o_rd_last=0.
//  i_rd_start outside READY ignored. i_done in IDLE ignored.
//  Edge detect on i_busy uses a registered copy (reset 0).
//  o_count is a registered output; stable in READY/READ.
// CONFIGURATION
//  SCOPE_CAPBUF_DECIM_EN defined: adds port i_decim (in, 8) ; writes occur on
//   every (i_decim+1)-th qualified strobe; decimation counter cleared on entry
//   to WRITE; i_decim=0 equals no decimation. i_decim sampled continuously.
//  Not defined: port absent, every qualified strobe writes.
// STRUCTURE
//  scope_pkg: DEPTH, ADDR_W, state encodings (ST_IDLE..ST_READ).
//  Sub-module scope_sample_ram: simple dual-port, sync write, registered read
//   (1-cycle latency), no reset on array; inferred as block RAM.
//  Top: FSM, pointers, counters, busy edge detect, read-outstanding flag.
// TESTING
//  1 Reset mid-WRITE (rst_n low 3 cycles) -> all outputs 0, state IDLE, count 0.
//  2 DEPTH=8, busy rise, 5 samples 10..14, done -> o_count=5; readout gives
//    10,11,12,13,14 with o_rd_last on 14.
//  3 DEPTH=8, 20 samples 0..19 then done -> o_count=8; readout 12..19, last on 19
//    (wrap-around check).
//  4 i_rd_req held high through readout -> o_rd_valid every 2nd cycle, 8 pulses,
//    no duplicates or skips.
//  5 busy rise during READ after 3 words -> 4th word valid pulse, o_rd_last=0,
//    state WRITE, o_ready=0, o_count=0.
//  6 SCOPE_CAPBUF_DECIM_EN, i_decim=2, samples 0..11 -> record 0,3,6,9, o_count=4.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared constants and FSM encoding for the scope capture path.
package scope_pkg;

  localparam int SCOPE_DEPTH  = 512;
  localparam int SCOPE_DATA_W = 8;
  localparam int SCOPE_ADDR_W = $clog2(SCOPE_DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_WRITE = 4'b0010,
    ST_READY = 4'b0100,
    ST_READ  = 4'b1000
  } state_t;

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read (1-cycle latency).
module scope_sample_ram #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/scope_capture_buffer.sv
// Circular capture buffer behind the scope trigger controller; streams the frozen record oldest-first.
// Optional decimation input i_decim is enabled by defining SCOPE_CAPBUF_DECIM_EN.
module scope_capture_buffer
  import scope_pkg::*;
#(
  parameter int DEPTH  = SCOPE_DEPTH,
  parameter int DATA_W = SCOPE_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_adc_data,
  input  logic              i_sample_en,
`ifdef SCOPE_CAPBUF_DECIM_EN
  input  logic [7:0]        i_decim,
`endif
  input  logic              i_busy,
  input  logic              i_done,
  input  logic              i_rd_start,
  input  logic              i_rd_req,
  output logic              o_ready,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_last,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t              r_state, w_state_nxt;
  logic                r_busy_q;
  logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]     r_count, r_rd_left;
  logic                r_rd_pend, r_rd_last;
  logic                w_busy_rise, w_decim_hit;
  logic                w_wr_en, w_rd_issue, w_rd_load, w_rearm;
  logic [DATA_W-1:0]   w_ram_q;

  assign w_busy_rise = i_busy & ~r_busy_q;

`ifdef SCOPE_CAPBUF_DECIM_EN
  logic       w_strobe;
  logic [7:0] r_decim_cnt;

  assign w_strobe    = (r_state == ST_WRITE) & i_sample_en & ~i_done;
  assign w_decim_hit = (r_decim_cnt == 8'd0);

  // The first qualified strobe after arming always writes; then every (i_decim+1)-th.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_decim_cnt <= 8'd0;
    else if (w_rearm)  r_decim_cnt <= 8'd0;
    else if (w_strobe) r_decim_cnt <= (r_decim_cnt >= i_decim) ? 8'd0 : r_decim_cnt + 8'd1;
  end
`else
  assign w_decim_hit = 1'b1;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_rd_issue  = 1'b0;
    w_rd_load   = 1'b0;
    w_rearm     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_busy_rise) begin
          w_state_nxt = ST_WRITE;
          w_rearm     = 1'b1;
        end
      end
      ST_WRITE: begin
        if (i_done)                          w_state_nxt = ST_READY;
        else if (i_sample_en && w_decim_hit) w_wr_en     = 1'b1;
      end
      ST_READY: begin
        if (w_busy_rise) begin
          w_state_nxt = ST_WRITE;
          w_rearm     = 1'b1;
        end else if (i_rd_start && (r_count != '0)) begin
          w_state_nxt = ST_READ;
          w_rd_load   = 1'b1;
        end
      end
      ST_READ: begin
        if (w_busy_rise) begin
          w_state_nxt = ST_WRITE;
          w_rearm     = 1'b1;
        end else if (i_rd_req && !r_rd_pend) begin
          w_rd_issue = 1'b1;
          if (r_rd_left == CNT_ONE) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_busy_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy_q <= i_busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_left <= '0;
      r_rd_pend <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      r_rd_last <= w_rd_issue && (r_rd_left == CNT_ONE);
      if (w_rearm)                            r_count <= '0;
      else if (w_wr_en && r_count != CNT_FULL) r_count <= r_count + CNT_ONE;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      // A full record starts at wr_ptr: count's low bits are zero then, so one subtract covers both cases.
      if (w_rd_load) begin
        r_rd_ptr  <= r_wr_ptr - r_count[ADDR_W-1:0];
        r_rd_left <= r_count;
      end else if (w_rd_issue) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_rd_left <= r_rd_left - CNT_ONE;
      end
    end
  end

  scope_sample_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_adc_data),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  assign o_ready    = (r_state == ST_READY) || (r_state == ST_READ);
  assign o_rd_valid = r_rd_pend;
  assign o_rd_last  = r_rd_last;
  assign o_rd_data  = r_rd_pend ? w_ram_q : '0;
  assign o_count    = r_count;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Scoreboard bench for scope_capture_buffer (DEPTH=8); the record model is a sliding-window queue.
module tb_scope_capture_buffer;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] i_adc_data = '0;
  logic              i_sample_en = 1'b0;
  logic              i_busy = 1'b0;
  logic              i_done = 1'b0;
  logic              i_rd_start = 1'b0;
  logic              i_rd_req = 1'b0;
  logic [7:0]        decim_val = 8'd0;
  logic              o_ready, o_rd_valid, o_rd_last;
  logic [DATA_W-1:0] o_rd_data;
  logic [3:0]        o_count;

  scope_capture_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_adc_data  (i_adc_data),
    .i_sample_en (i_sample_en),
`ifdef SCOPE_CAPBUF_DECIM_EN
    .i_decim     (decim_val),
`endif
    .i_busy      (i_busy),
    .i_done      (i_done),
    .i_rd_start  (i_rd_start),
    .i_rd_req    (i_rd_req),
    .o_ready     (o_ready),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .o_rd_last   (o_rd_last),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t            exp_q[$];
  logic [7:0]      record_q[$];
  int              strobe_idx = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              n_pulses = 0;
  int              exp_count = 0;
  int              cyc = 0;
  int              prev_cyc = -1;
  bit              hold_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a record is the last DEPTH accepted samples since arming.
  task automatic model_arm();
    record_q.delete();
    strobe_idx = 0;
  endtask

  task automatic model_strobe(input logic [7:0] d);
    if (strobe_idx % (int'(decim_val) + 1) == 0) begin
      record_q.push_back(d);
      if (record_q.size() > DEPTH) void'(record_q.pop_front());
    end
    strobe_idx++;
  endtask

  task automatic arm();
    i_busy = 1'b1;
    tick();
    i_busy = 1'b0;
    model_arm();
  endtask

  task automatic fill(input int n, input bit seq, input int base, input bit gaps);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_sample_en = 1'b0;
        i_adc_data  = 8'($urandom);
        tick();
      end
      d = seq ? 8'(base + k) : 8'($urandom);
      i_sample_en = 1'b1;
      i_adc_data  = d;
      tick();
      model_strobe(d);
    end
    i_sample_en = 1'b0;
  endtask

  task automatic finish_done();
    i_done      = 1'b1;
    i_sample_en = 1'b1;
    i_adc_data  = 8'($urandom);
    tick();
    i_done      = 1'b0;
    i_sample_en = 1'b0;
    check("ready_after_done", o_ready, 1);
    check("count_after_done", o_count, record_q.size());
  endtask

  task automatic readout(input bit hold);
    int n, target, t;
    n = record_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back('{data: record_q[i], last: (i == n - 1)});
    exp_count = n;
    target    = n_pulses + n;
    prev_cyc  = -1;
    hold_mode = hold;
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    t = 0;
    while (n_pulses < target && t < 400) begin
      i_rd_req = hold ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      t++;
    end
    i_rd_req  = 1'b0;
    hold_mode = 1'b0;
    check("readout_pulses", n_pulses, target);
    check("ready_after_read", o_ready, 0);
    exp_q.delete();
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every valid pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rd_valid) begin
        check("valid_has_expectation", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rd_data", o_rd_data, e.data);
          check("rd_last", o_rd_last, e.last);
          check("count_during_read", o_count, exp_count);
          if (hold_mode && prev_cyc >= 0) check("valid_spacing", cyc - prev_cyc, 2);
          prev_cyc = cyc;
        end
        n_pulses++;
      end else if (o_rd_last) begin
        check("last_without_valid", o_rd_last, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", o_ready, 0);
    check("reset_valid", o_rd_valid, 0);
    check("reset_data", o_rd_data, 0);
    check("reset_last", o_rd_last, 0);
    check("reset_count", o_count, 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of a capture.
    arm();
    fill(3, 1'b0, 0, 1'b0);
    rst_n  = 1'b0;
    i_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_ready", o_ready, 0);
    check("midrst_count", o_count, 0);
    check("midrst_valid", o_rd_valid, 0);
    check("midrst_data", o_rd_data, 0);
    rst_n = 1'b1;
    model_arm();
    tick();

    // Done, start and requests while idle are all ignored.
    p = n_pulses;
    i_done = 1'b1; tick(); i_done = 1'b0;
    i_rd_start = 1'b1; i_rd_req = 1'b1; tick();
    i_rd_start = 1'b0; tick(); tick(); i_rd_req = 1'b0;
    check("idle_ignores_ready", o_ready, 0);
    check("idle_no_pulses", n_pulses, p);

    // Short record, paced requests.
    arm();
    fill(5, 1'b1, 10, 1'b0);
    finish_done();
    readout(1'b0);

    // Wrapped record read with request held high.
    arm();
    fill(20, 1'b1, 0, 1'b1);
    finish_done();
    readout(1'b1);

    // Empty record: start is refused, buffer stays READY.
    arm();
    finish_done();
    p = n_pulses;
    i_rd_start = 1'b1; tick(); i_rd_start = 1'b0;
    i_rd_req = 1'b1; repeat (4) tick(); i_rd_req = 1'b0;
    check("empty_stays_ready", o_ready, 1);
    check("empty_no_pulses", n_pulses, p);

    // Re-arm in the middle of a readout.
    arm();
    fill(8, 1'b1, 100, 1'b0);
    finish_done();
    p = n_pulses;
    for (int i = 0; i < 8; i++) exp_q.push_back('{data: record_q[i], last: (i == 7)});
    exp_count = 8;
    i_rd_start = 1'b1; tick(); i_rd_start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      i_rd_req = 1'b1; tick(); i_rd_req = 1'b0; tick();
    end
    check("abort_three_words", n_pulses - p, 3);
    i_rd_req = 1'b1; tick(); i_rd_req = 1'b0;
    i_busy = 1'b1; tick(); i_busy = 1'b0;
    model_arm();
    check("abort_fourth_pulse", n_pulses - p, 4);
    check("abort_ready", o_ready, 0);
    check("abort_count", o_count, 0);
    exp_q.delete();
    tick();
    check("abort_no_extra_valid", n_pulses - p, 4);
    fill(3, 1'b0, 0, 1'b0);
    finish_done();
    readout(1'b0);

`ifdef SCOPE_CAPBUF_DECIM_EN
    decim_val = 8'd2;
    arm();
    fill(12, 1'b1, 0, 1'b0);
    finish_done();
    check("decim_count", o_count, 4);
    readout(1'b1);
    decim_val = 8'd0;
`endif

    // Randomised records of assorted length, gaps and request patterns.
    for (int r = 0; r < 6; r++) begin
      arm();
      fill($urandom_range(1, 20), 1'b0, 0, 1'b1);
      finish_done();
      readout(1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
